// File: rtl/apb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : apb_pkg
// Description : Shared definitions for the APB requester slice: the
//               requester FSM state type and the default bus widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Default APB address and data widths
    localparam int c_ADDR_W = 4;
    localparam int c_DATA_W = 8;

    // Requester FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_requester_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : apb_requester_if
// Description : Bundles the command/response handshake and the APB bus of
//               the requester.
// Ports       : master modport - requester view (takes commands and APB
//                                 returns, drives response and APB controls)
//               slave modport  - environment view (command source, response
//                                 sink and APB responder)
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_requester_if #(
    parameter int ADDR_W = apb_pkg::c_ADDR_W,
    parameter int DATA_W = apb_pkg::c_DATA_W
) ();

    // Command side
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // Response side
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // APB bus
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, pready, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, pready, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface : apb_requester_if
`default_nettype wire

// File: rtl/apb_req_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : apb_req_timer
// Description : Counts ACCESS cycles spent waiting for pready. Only
//               instantiated when APB_REQ_TIMEOUT_EN is defined.
// Ports       : pclk    in  clock
//               prstn   in  asynchronous active-low reset
//               clear   in  restart the count (entry into ACCESS)
//               inc     in  one more ACCESS cycle without pready
//               expired out the count reaches TIMEOUT_CYC on this edge
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic pclk,
    input  logic prstn,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    // Flags the edge on which the count would become TIMEOUT_CYC, so the
    // FSM leaves ACCESS after exactly TIMEOUT_CYC stalled cycles.
    assign expired = inc && (r_count == c_CNT_W'(TIMEOUT_CYC - 1));

endmodule : apb_req_timer
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : apb_requester
// Description : Turns single commands into APB transfers (IDLE -> SETUP ->
//               ACCESS) and reports each completion with a one-cycle
//               response pulse. Defining APB_REQ_TIMEOUT_EN adds a bounded
//               wait for pready that completes with rsp_err=1.
// Ports       : pclk   in  clock, rising edge
//               prstn  in  asynchronous active-low reset
//               bus    apb_requester_if.master - command, response, APB
// Revision    : 1.0 - initial release
// ============================================================================
module apb_requester #(
    parameter int ADDR_W      = apb_pkg::c_ADDR_W,
    parameter int DATA_W      = apb_pkg::c_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            pclk,
    input  logic            prstn,
    apb_requester_if.master bus
);

    import apb_pkg::*;

    apb_state_t        r_state;
    apb_state_t        w_next;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_done;
    logic              w_timeout;
    logic              w_expired;

    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYC must be at least 1");
    end

    assign w_accept = w_req_ready && bus.req_valid;

`ifdef APB_REQ_TIMEOUT_EN
    logic r_rsp_err;

    // SETUP always precedes ACCESS, so clearing there restarts the count
    // on every entry into ACCESS.
    apb_req_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .pclk    (pclk),
        .prstn   (prstn),
        .clear   (r_state == ST_SETUP),
        .inc     ((r_state == ST_ACCESS) && !bus.pready),
        .expired (w_expired)
    );

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_timeout;
        end
    end

    assign bus.rsp_err = r_rsp_err;
`else
    assign w_expired   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // State register
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-cycle strobes
    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready wins over an expiring count on the same edge
                if (bus.pready) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Command capture and response registers. The APB address/data hold
    // their last values in IDLE because they only load on acceptance.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_pwrite <= bus.req_write;
                r_paddr  <= bus.req_addr;
                r_pwdata <= bus.req_wdata;
            end
            r_rsp_valid <= w_done || w_timeout;
            r_rsp_rdata <= (w_done && !r_pwrite) ? bus.prdata : '0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.psel      = (r_state != ST_IDLE);
    assign bus.penable   = (r_state == ST_ACCESS);
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule : apb_requester
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_apb_requester
// Description : Self-checking bench for apb_requester. A transaction-level
//               model tracks each command from acceptance to response and
//               is compared with the DUT every cycle; directed tests pin
//               the model with literal expectations. Build with
//               APB_REQ_TIMEOUT_EN defined to include the timeout tests.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_requester;

    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16;

    logic pclk  = 1'b0;
    logic prstn = 1'b0;

    always #5 pclk = ~pclk;

    apb_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_requester #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .pclk  (pclk),
        .prstn (prstn),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    always @(posedge pclk) cyc++;

    // ------------------------------------------------------------------
    // APB responder: mode 0 ready at once, 1 ready after wait_n stalled
    // ACCESS cycles, 2 never ready, 3 random ready. Reads come from mem.
    // ------------------------------------------------------------------
    int         mode   = 0;
    int         wait_n = 0;
    int         acc_k  = 0;
    logic [7:0] mem [16];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        bus.pready = 1'b0;
        bus.prdata = 8'h00;
    end

    always @(posedge pclk) begin
        #1;
        if (bus.psel && bus.penable) acc_k++;
        else acc_k = 0;
        case (mode)
            0:       bus.pready = 1'b1;
            1:       bus.pready = (acc_k > wait_n);
            2:       bus.pready = 1'b0;
            default: bus.pready = ($urandom_range(0, 3) != 0);
        endcase
        bus.prdata = mem[bus.paddr];
    end

    // ------------------------------------------------------------------
    // Transaction model: a command is "in flight" from the cycle after
    // acceptance; its first cycle is the setup phase, the rest access
    // phase, ending on pready (or the timeout); the response follows one
    // cycle later. Checked on every falling edge.
    // ------------------------------------------------------------------
    logic       m_busy  = 1'b0;
    int         m_t     = 0;
    logic       m_write = 1'b0;
    logic [3:0] m_addr  = 4'h0;
    logic [7:0] m_wdata = 8'h00;
    logic       m_rv    = 1'b0;
    logic [7:0] m_rd    = 8'h00;
    logic       m_re    = 1'b0;

    int         psel_cnt = 0;
    int         pen_cnt  = 0;
    int         rsp_cnt  = 0;
    logic [8:0] rsp_log [$];

    always @(negedge pclk) begin
        if (!prstn) begin
            chk("rst_psel",      32'(bus.psel),      32'd0);
            chk("rst_penable",   32'(bus.penable),   32'd0);
            chk("rst_pwrite",    32'(bus.pwrite),    32'd0);
            chk("rst_paddr",     32'(bus.paddr),     32'd0);
            chk("rst_pwdata",    32'(bus.pwdata),    32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
            chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
            m_busy = 1'b0; m_t = 0; m_write = 1'b0; m_addr = 4'h0; m_wdata = 8'h00;
            m_rv = 1'b0; m_rd = 8'h00; m_re = 1'b0;
        end else begin
            chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
            chk("psel",      32'(bus.psel),      32'(m_busy));
            chk("penable",   32'(bus.penable),   32'(m_busy && m_t >= 2));
            chk("pwrite",    32'(bus.pwrite),    32'(m_write));
            chk("paddr",     32'(bus.paddr),     32'(m_addr));
            chk("pwdata",    32'(bus.pwdata),    32'(m_wdata));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rd));
            chk("rsp_err",   32'(bus.rsp_err),   32'(m_re));

            if (bus.psel)      psel_cnt++;
            if (bus.penable)   pen_cnt++;
            if (bus.rsp_valid) begin
                rsp_cnt++;
                rsp_log.push_back({bus.rsp_err, bus.rsp_rdata});
            end
            if (bus.psel && bus.penable && bus.pready && bus.pwrite)
                mem[bus.paddr] = bus.pwdata;

            m_rv = 1'b0; m_rd = 8'h00; m_re = 1'b0;
            if (!m_busy) begin
                if (bus.req_valid) begin
                    m_busy  = 1'b1;
                    m_t     = 1;
                    m_write = bus.req_write;
                    m_addr  = bus.req_addr;
                    m_wdata = bus.req_wdata;
                end
            end else if (m_t == 1) begin
                m_t = 2;
            end else if (bus.pready) begin
                m_busy = 1'b0;
                m_rv   = 1'b1;
                m_rd   = m_write ? 8'h00 : bus.prdata;
`ifdef APB_REQ_TIMEOUT_EN
            end else if (m_t - 1 >= TIMEOUT_CYC) begin
                m_busy = 1'b0;
                m_rv   = 1'b1;
                m_re   = 1'b1;
`endif
            end else begin
                m_t++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command driver: offer, wait for acceptance, wait for the response
    // ------------------------------------------------------------------
    task automatic do_cmd(input logic w, input logic [3:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic er);
        int n;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("rsp_wait", 32'(bus.rsp_valid), 32'd1);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
    endtask

    task automatic clr_cnt();
        psel_cnt = 0;
        pen_cnt  = 0;
        rsp_cnt  = 0;
    endtask

    logic [7:0] sb_mem [16];
    logic [7:0] rd;
    logic       er;
    int         acc_cyc [4];
    logic [3:0] b2b_addr  [4];
    logic [7:0] b2b_wdata [4];
    logic       b2b_write [4];
    logic [8:0] b2b_exp   [4];

    initial begin
        for (int i = 0; i < 16; i++) sb_mem[i] = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'h0;
        bus.req_wdata = 8'h00;

        // Reset, then ready to accept
        repeat (3) tick();
        prstn = 1'b1;
        tick();
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

        // Write 3 <- A5, pready in the first ACCESS cycle
        mode = 0;
        clr_cnt();
        do_cmd(1'b1, 4'h3, 8'hA5, rd, er);
        tick();
        chk("wr_psel_cycles",  32'(psel_cnt), 32'd2);
        chk("wr_pen_cycles",   32'(pen_cnt),  32'd1);
        chk("wr_rsp_count",    32'(rsp_cnt),  32'd1);
        chk("wr_rsp_err",      32'(er),       32'd0);
        chk("wr_rsp_rdata",    32'(rd),       32'd0);
        chk("idle_hold_paddr", 32'(bus.paddr),  32'h3);
        chk("idle_hold_pwdata",32'(bus.pwdata), 32'hA5);
        chk("idle_hold_pwrite",32'(bus.pwrite), 32'd1);
        sb_mem[3] = 8'hA5;

        // Read 3 with three stalled ACCESS cycles
        mode   = 1;
        wait_n = 3;
        clr_cnt();
        do_cmd(1'b0, 4'h3, 8'h00, rd, er);
        tick();
        chk("rd_pen_cycles",  32'(pen_cnt),  32'd4);
        chk("rd_psel_cycles", 32'(psel_cnt), 32'd5);
        chk("rd_rsp_rdata",   32'(rd),       32'hA5);
        chk("rd_rsp_err",     32'(er),       32'd0);

        // Four back-to-back commands with req_valid held high
        mode = 0;
        rsp_log.delete();
        b2b_write[0] = 1'b1; b2b_addr[0] = 4'h5; b2b_wdata[0] = 8'h11; b2b_exp[0] = 9'h000;
        b2b_write[1] = 1'b1; b2b_addr[1] = 4'h6; b2b_wdata[1] = 8'h22; b2b_exp[1] = 9'h000;
        b2b_write[2] = 1'b0; b2b_addr[2] = 4'h5; b2b_wdata[2] = 8'h00; b2b_exp[2] = 9'h011;
        b2b_write[3] = 1'b0; b2b_addr[3] = 4'h6; b2b_wdata[3] = 8'h00; b2b_exp[3] = 9'h022;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n;
            bus.req_write = b2b_write[i];
            bus.req_addr  = b2b_addr[i];
            bus.req_wdata = b2b_wdata[i];
            n = 0;
            while (!bus.req_ready && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_accept", 32'(bus.req_ready), 32'd1);
            acc_cyc[i] = cyc;
            tick();
        end
        bus.req_valid = 1'b0;
        for (int k = 0; k < 20 && rsp_log.size() < 4; k++) tick();
        for (int i = 1; i < 4; i++)
            chk("b2b_period", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        chk("b2b_rsp_count", 32'(rsp_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rsp_log.size(); i++)
            chk("b2b_rsp_order", 32'(rsp_log[i]), 32'(b2b_exp[i]));
        sb_mem[5] = 8'h11;
        sb_mem[6] = 8'h22;

        // Reset in the middle of ACCESS
        mode = 2;
        rsp_log.delete();
        bus.req_write = 1'b0;
        bus.req_addr  = 4'h5;
        bus.req_valid = 1'b1;
        tick();                 // accepted at this edge -> SETUP
        bus.req_valid = 1'b0;
        tick();                 // ACCESS 1
        tick();                 // ACCESS 2
        chk("pre_rst_penable", 32'(bus.penable), 32'd1);
        prstn = 1'b0;
        #1;
        chk("rst_now_psel",    32'(bus.psel),    32'd0);
        chk("rst_now_penable", 32'(bus.penable), 32'd0);
        tick();
        prstn = 1'b1;
        mode  = 0;
        repeat (3) tick();
        chk("rst_no_rsp", 32'(rsp_log.size()), 32'd0);
        do_cmd(1'b0, 4'h6, 8'h00, rd, er);
        chk("post_rst_rdata", 32'(rd), 32'h22);
        chk("post_rst_err",   32'(er), 32'd0);

`ifdef APB_REQ_TIMEOUT_EN
        // pready stuck low: timeout after TIMEOUT_CYC ACCESS cycles
        mode = 2;
        clr_cnt();
        do_cmd(1'b0, 4'h7, 8'h00, rd, er);
        tick();
        chk("to_pen_cycles",  32'(pen_cnt),  32'd16);
        chk("to_psel_cycles", 32'(psel_cnt), 32'd17);
        chk("to_rsp_err",     32'(er),       32'd1);
        chk("to_rsp_rdata",   32'(rd),       32'd0);

        // pready on the very edge the count expires: normal completion
        mode   = 1;
        wait_n = 15;
        clr_cnt();
        do_cmd(1'b0, 4'h5, 8'h00, rd, er);
        tick();
        chk("edge_pen_cycles", 32'(pen_cnt), 32'd16);
        chk("edge_rsp_err",    32'(er),      32'd0);
        chk("edge_rsp_rdata",  32'(rd),      32'h11);
`endif

        // Random traffic against the memory responder
        mode = 3;
        for (int i = 0; i < 200; i++) begin
            logic       w;
            logic [3:0] a;
            logic [7:0] d;
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            do_cmd(w, a, d, rd, er);
            chk("rand_err", 32'(er), 32'd0);
            if (w) sb_mem[a] = d;
            else   chk("rand_read", 32'(rd), 32'(sb_mem[a]));
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_apb_requester
`default_nettype wire
